data_mem_lsu: RTL and testbench
===============================

Name: data_mem_lsu

Overview:
Parametrised byte-addressable data memory with a RISC-V load/store front end, used by the core's MEM stage.
- Accepts one load or store per request through a valid/ready handshake.
- Stores apply byte-lane masks for SB/SH/SW.
- Loads are sign- or zero-extended for LB/LH/LW/LBU/LHU.
- Response latency is configurable through inserted wait states.
- Misaligned, out-of-range and illegal-size requests are reported as faults and never touch memory.

Parameters:
XLEN, 32, data/address width in bits; fixed at 32 (4 byte lanes).
DEPTH, 1024, memory depth in XLEN-bit words; power of two, at least 4.
WAIT_CYCLES, 0, extra access latency in cycles; range 0..15.

Ports:
i_clk  in  1  clock; all state changes on the rising edge.
i_rst_n  in  1  asynchronous, active-low reset.
i_req_valid  in  1  request present.
o_req_ready  out  1  block can accept a request.
i_we  in  1  1 = store, 0 = load.
i_funct3  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
i_addr  in  XLEN  byte address.
i_wdata  in  XLEN  store data, right-aligned.
o_rsp_valid  out  1  one-cycle response strobe.
o_rdata  out  XLEN  extended load data; 0 for stores and faults.
o_fault  out  1  request faulted; qualified by o_rsp_valid.
o_fault_cause  out  2  01 misaligned, 10 out of range, 11 illegal funct3; 00 when no fault.

Behaviour:
- Reset (async, i_rst_n=0):
  - FSM goes to IDLE; o_req_ready=1, o_rsp_valid=0, o_rdata=0, o_fault=0, o_fault_cause=00, wait counter=0.
  - Memory array is not reset; contents persist across reset.
- FSM states: IDLE, WAIT, RESP. o_req_ready=1 only in IDLE.
- Acceptance: a request is accepted on an edge where i_req_valid & o_req_ready. The block latches i_we, i_funct3, i_addr and i_wdata; later input changes are ignored.
- Fault check, evaluated at acceptance, highest priority first:
  1. Illegal funct3 → cause 11. Illegal codes are 011, 11x, and for stores also 100/101.
  2. Misaligned → cause 01. H/HU with addr[0]=1; W with addr[1:0]≠0.
  3. Out of range → cause 10. i_addr ≥ DEPTH*4.
- Faulted request: go IDLE→RESP directly, with no memory access. Response carries o_fault=1, o_rdata=0.
- Legal request, WAIT_CYCLES=0: the access happens on the acceptance edge, then the FSM goes to RESP.
- Legal request, WAIT_CYCLES>0:
  - On acceptance, go to WAIT with counter=WAIT_CYCLES-1.
  - In WAIT, decrement the counter each cycle.
  - On the edge where counter==0, perform the access and go to RESP.
- Latency: o_rsp_valid rises 1+WAIT_CYCLES cycles after the accept edge (faults: 1 cycle).
- RESP:
  - o_rsp_valid=1 for exactly one cycle; there is no response backpressure.
  - Next state is IDLE; o_rsp_valid returns to 0.
  - o_rdata, o_fault and o_fault_cause hold until the next response.
- Word index is addr[log2(DEPTH)+1:2]; lane is addr[1:0].
- Store lane writes:
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Unselected lanes are unchanged.
- Load extraction and extension:
  - LB and LH sign-extend bit 7 / bit 15 of the selected bytes.
  - LBU and LHU zero-extend.
  - LW returns the whole word.
- Read data is registered from the array at the access edge. A load issued immediately after a store to the same address returns the stored value.
- Reset mid-operation (WAIT or RESP): the pending request is dropped and no response is produced. A store still in WAIT is not committed.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → o_rdata=0xDEADBEEF, o_fault=0; with WAIT_CYCLES=0, o_rsp_valid exactly 1 cycle after each accept.
- SB 0x13 data 0x80 over word 0x11223344 at 0x10, then LB 0x13 → 0xFFFFFF80, LBU 0x13 → 0x00000080, LW 0x10 → 0x80223344.
- SH 0x22 data 0xF00D, then LH 0x22 → 0xFFFFF00D and LHU 0x22 → 0x0000F00D; bytes 0x20/0x21 unchanged.
- LW 0x12 → fault cause 01; SB 0x1000 at DEPTH=1024 → cause 10; store with funct3=100 → cause 11. Memory is unchanged in all three cases; o_rsp_valid is 1 cycle after accept.
- WAIT_CYCLES=3: LW accepted at cycle N → o_rsp_valid at N+4, o_req_ready=0 during N+1..N+4; i_req_valid held high is next accepted at N+5.
- WAIT_CYCLES=3: SW 0x40 data 0x12345678, with i_rst_n pulsed low 1 cycle after accept → no response; after reset, LW 0x40 returns the prior contents.

Source files
------------

// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory with a RISC-V load/store front end.
// One request in flight; faults are answered without touching the array.
module data_mem_lsu #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_we,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_rsp_valid,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_fault,
  output logic [1:0]      o_fault_cause
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = AW + 2;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
  localparam logic [63:0]   LIMIT    = 64'(DEPTH) << 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_next;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [BW-1:0]     r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [CW-1:0]     r_cnt;
  logic              r_req_ready, r_rsp_valid, r_fault;
  logic [XLEN-1:0]   r_rdata;
  logic [1:0]        r_cause;
  logic [XLEN-1:0]   r_mem [DEPTH];

  logic              w_accept, w_access;
  logic              w_illegal, w_misal, w_oor;
  logic [1:0]        w_cause;
  logic              w_we;
  logic [2:0]        w_f3;
  logic [BW-1:0]     w_addr;
  logic [XLEN-1:0]   w_wdata, w_word, w_wrep, w_load;
  logic [AW-1:0]     w_idx;
  logic [1:0]        w_lane;
  logic [3:0]        w_wmask;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  assign w_accept = i_req_valid && (r_state == S_IDLE);

  // Fault classification of the incoming request, highest priority first
  always_comb begin
    w_illegal = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11) || (i_we && i_funct3[2]);
    w_misal   = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    w_oor     = 64'(i_addr) >= LIMIT;
    w_cause   = 2'b00;
    if (w_illegal)    w_cause = 2'b11;
    else if (w_misal) w_cause = 2'b01;
    else if (w_oor)   w_cause = 2'b10;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_access = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_cause != 2'b00) begin
            w_next = S_RESP;
          end else if (WAIT_CYCLES == 0) begin
            w_next   = S_RESP;
            w_access = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_next   = S_RESP;
          w_access = 1'b1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Zero-wait accesses use the live request; delayed ones use the latched copy
  always_comb begin
    w_we    = (r_state == S_IDLE) ? i_we           : r_we;
    w_f3    = (r_state == S_IDLE) ? i_funct3       : r_f3;
    w_addr  = (r_state == S_IDLE) ? i_addr[BW-1:0] : r_addr;
    w_wdata = (r_state == S_IDLE) ? i_wdata        : r_wdata;
    w_idx   = w_addr[BW-1:2];
    w_lane  = w_addr[1:0];
    w_word  = r_mem[w_idx];
    w_byte  = w_word[{w_lane, 3'b000} +: 8];
    w_half  = w_word[{w_lane[1], 4'b0000} +: 16];
    w_wmask = 4'b0000;
    w_wrep  = w_wdata;
    case (w_f3[1:0])
      2'b00: begin
        w_wmask = 4'b0001 << w_lane;
        w_wrep  = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_wmask = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wrep  = {2{w_wdata[15:0]}};
      end
      2'b10:   w_wmask = 4'b1111;
      default: w_wmask = 4'b0000;
    endcase
    case (w_f3)
      3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
      default: w_load = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we        <= 1'b0;
      r_f3        <= 3'b000;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_fault     <= 1'b0;
      r_cause     <= 2'b00;
    end else begin
      if (w_accept) begin
        r_we    <= i_we;
        r_f3    <= i_funct3;
        r_addr  <= i_addr[BW-1:0];
        r_wdata <= i_wdata;
        r_cnt   <= CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end
      r_req_ready <= (w_next == S_IDLE);
      r_rsp_valid <= (w_next == S_RESP);
      if (w_access) begin
        r_rdata <= w_we ? '0 : w_load;
        r_fault <= 1'b0;
        r_cause <= 2'b00;
      end else if (w_accept && (w_cause != 2'b00)) begin
        r_rdata <= '0;
        r_fault <= 1'b1;
        r_cause <= w_cause;
      end
    end
  end

  // Array is deliberately not reset; contents survive i_rst_n
  always_ff @(posedge i_clk) begin
    if (w_access && w_we) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (w_wmask[l]) r_mem[w_idx][8*l +: 8] <= w_wrep[8*l +: 8];
      end
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rdata       = r_rdata;
  assign o_fault       = r_fault;
  assign o_fault_cause = r_cause;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: one instance with no wait states, one with three,
// checked against directed vectors and a byte-array reference model.
module tb_data_mem_lsu;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned BYTES = DEPTH * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, v0, we0, rdy0, rv0, flt0;
  logic [2:0] f30;
  logic [31:0] a0, wd0, rd0;
  logic [1:0] cs0;
  logic rst3_n, v3, we3, rdy3, rv3, flt3;
  logic [2:0] f33;
  logic [31:0] a3, wd3, rd3;
  logic [1:0] cs3;

  data_mem_lsu #(.XLEN(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst0_n), .i_req_valid(v0), .o_req_ready(rdy0),
    .i_we(we0), .i_funct3(f30), .i_addr(a0), .i_wdata(wd0),
    .o_rsp_valid(rv0), .o_rdata(rd0), .o_fault(flt0), .o_fault_cause(cs0));

  data_mem_lsu #(.XLEN(32), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst3_n), .i_req_valid(v3), .o_req_ready(rdy3),
    .i_we(we3), .i_funct3(f33), .i_addr(a3), .i_wdata(wd3),
    .o_rsp_valid(rv3), .o_rdata(rd3), .o_fault(flt3), .o_fault_cause(cs3));

  typedef struct packed {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        flt;
    logic [1:0]  cs;
  } obs_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] erd;
    logic        ef;
    logic [1:0]  ec;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] mm [2][BYTES];

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endfunction

  function automatic obs_t obs(input int sel);
    obs_t o;
    if (sel == 0) o = '{rdy0, rv0, rd0, flt0, cs0};
    else          o = '{rdy3, rv3, rd3, flt3, cs3};
    return o;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    if (sel == 0) begin v0 = v; we0 = we; f30 = f3; a0 = addr; wd0 = wd; end
    else          begin v3 = v; we3 = we; f33 = f3; a3 = addr; wd3 = wd; end
  endtask

  // Reference: little-endian byte memory, fault rules straight from the ISA sizes
  function automatic void model(input int sel, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] erd, output logic ef, output logic [1:0] ec);
    int size;
    logic [31:0] val;
    logic illegal;
    size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    illegal = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4);
    erd = 32'h0; ef = 1'b1; ec = 2'b00;
    if (illegal)                   ec = 2'b11;
    else if ((addr % size) != 0)   ec = 2'b01;
    else if (addr >= 32'(BYTES))   ec = 2'b10;
    else begin
      ef = 1'b0;
      if (we) begin
        for (int i = 0; i < size; i++) mm[sel][addr + 32'(i)] = 8'((wd >> (8 * i)) & 32'hFF);
      end else begin
        val = 32'h0;
        for (int i = 0; i < size; i++) val = val | ({24'h0, mm[sel][addr + 32'(i)]} << (8 * i));
        if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8 * size)) - 32'd1);
        erd = val;
      end
    end
  endfunction

  task automatic do_req(input int sel, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                        output logic [31:0] rd, output logic flt, output logic [1:0] cs,
                        output logic [31:0] rd_next);
    int g, lat;
    logic rdy_bad;
    obs_t o;
    @(negedge clk);
    set_in(sel, 1'b1, we, f3, addr, wd);
    g = 0;
    while (!obs(sel).rdy && g < 50) begin @(negedge clk); g++; end
    @(posedge clk);
    @(negedge clk);
    set_in(sel, 1'b0, ~we, ~f3, ~addr, ~wd);
    lat = 1; rdy_bad = 1'b0; o = obs(sel);
    while (!o.rv && lat < 40) begin
      if (o.rdy) rdy_bad = 1'b1;
      @(negedge clk); lat++; o = obs(sel);
    end
    if (o.rdy) rdy_bad = 1'b1;
    rd = o.rd; flt = o.flt; cs = o.cs;
    chk($sformatf("latency@%h", addr), 32'(lat), 32'(exp_lat));
    chk($sformatf("busy_ready@%h", addr), 32'(rdy_bad), 32'h0);
    @(negedge clk);
    o = obs(sel);
    chk($sformatf("pulse_end@%h", addr), {30'h0, o.rv, o.rdy}, 32'h1);
    rd_next = o.rd;
  endtask

  task automatic run_op(input int sel, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] erd, rd, rdn;
    logic ef, flt;
    logic [1:0] ec, cs;
    model(sel, we, f3, addr, wd, erd, ef, ec);
    do_req(sel, we, f3, addr, wd, ef ? 1 : (sel == 0 ? 1 : 4), rd, flt, cs, rdn);
    chk($sformatf("rdata%0d@%h", sel, addr), rd, erd);
    chk($sformatf("fault%0d@%h", sel, addr), 32'(flt), 32'(ef));
    chk($sformatf("cause%0d@%h", sel, addr), 32'(cs), 32'(ec));
    chk($sformatf("hold%0d@%h", sel, addr), rdn, erd);
  endtask

  task automatic random_ops(input int sel, input int n);
    logic [2:0] pool [13];
    logic [31:0] addr;
    int r;
    pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int k = 0; k < 64; k++) run_op(sel, 1'b1, 3'b010, 32'(k * 4), $urandom());
    run_op(sel, 1'b1, 3'b010, 32'hFFC, $urandom());
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      addr = 32'h1000 + 32'($urandom_range(0, 255));
      else if (r == 1) addr = $urandom() | 32'h8000_0000;
      else if (r == 2) addr = 32'hFFC + 32'($urandom_range(0, 3));
      else             addr = 32'($urandom_range(0, 255));
      run_op(sel, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 12)], addr, $urandom());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl [31];
    obs_t o;
    logic [31:0] rd, rdn, erd, rd4;
    logic flt, ef, saw;
    logic [1:0] cs, ec;
    logic [4:0] rdyb, rvb;
    int g, lat;

    tbl[0]  = '{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2'b00};
    tbl[1]  = '{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 2'b00};
    tbl[2]  = '{1'b1, 3'b010, 32'h10,   32'h11223344, 32'h0,        1'b0, 2'b00};
    tbl[3]  = '{1'b1, 3'b000, 32'h13,   32'hABCDEF80, 32'h0,        1'b0, 2'b00};
    tbl[4]  = '{1'b0, 3'b000, 32'h13,   32'h0,        32'hFFFFFF80, 1'b0, 2'b00};
    tbl[5]  = '{1'b0, 3'b100, 32'h13,   32'h0,        32'h00000080, 1'b0, 2'b00};
    tbl[6]  = '{1'b0, 3'b010, 32'h10,   32'h0,        32'h80223344, 1'b0, 2'b00};
    tbl[7]  = '{1'b1, 3'b010, 32'h20,   32'h12345678, 32'h0,        1'b0, 2'b00};
    tbl[8]  = '{1'b1, 3'b001, 32'h22,   32'h9999F00D, 32'h0,        1'b0, 2'b00};
    tbl[9]  = '{1'b0, 3'b001, 32'h22,   32'h0,        32'hFFFFF00D, 1'b0, 2'b00};
    tbl[10] = '{1'b0, 3'b101, 32'h22,   32'h0,        32'h0000F00D, 1'b0, 2'b00};
    tbl[11] = '{1'b0, 3'b010, 32'h20,   32'h0,        32'hF00D5678, 1'b0, 2'b00};
    tbl[12] = '{1'b0, 3'b010, 32'h12,   32'h0,        32'h0,        1'b1, 2'b01};
    tbl[13] = '{1'b1, 3'b000, 32'h1000, 32'h55,       32'h0,        1'b1, 2'b10};
    tbl[14] = '{1'b1, 3'b100, 32'h10,   32'h0,        32'h0,        1'b1, 2'b11};
    tbl[15] = '{1'b0, 3'b010, 32'h10,   32'h0,        32'h80223344, 1'b0, 2'b00};
    tbl[16] = '{1'b1, 3'b101, 32'h20,   32'h0,        32'h0,        1'b1, 2'b11};
    tbl[17] = '{1'b0, 3'b100, 32'h21,   32'h0,        32'h00000056, 1'b0, 2'b00};
    tbl[18] = '{1'b0, 3'b011, 32'h10,   32'h0,        32'h0,        1'b1, 2'b11};
    tbl[19] = '{1'b0, 3'b110, 32'h13,   32'h0,        32'h0,        1'b1, 2'b11};
    tbl[20] = '{1'b0, 3'b001, 32'h1001, 32'h0,        32'h0,        1'b1, 2'b01};
    tbl[21] = '{1'b1, 3'b010, 32'hFFC,  32'hCAFEBABE, 32'h0,        1'b0, 2'b00};
    tbl[22] = '{1'b0, 3'b000, 32'hFFF,  32'h0,        32'hFFFFFFCA, 1'b0, 2'b00};
    tbl[23] = '{1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1, 2'b10};
    tbl[24] = '{1'b1, 3'b001, 32'h1002, 32'h0,        32'h0,        1'b1, 2'b10};
    tbl[25] = '{1'b0, 3'b101, 32'hFFE,  32'h0,        32'h0000CAFE, 1'b0, 2'b00};
    tbl[26] = '{1'b1, 3'b000, 32'h11,   32'h0000007F, 32'h0,        1'b0, 2'b00};
    tbl[27] = '{1'b0, 3'b000, 32'h11,   32'h0,        32'h0000007F, 1'b0, 2'b00};
    tbl[28] = '{1'b0, 3'b010, 32'h10,   32'h0,        32'h80227F44, 1'b0, 2'b00};
    tbl[29] = '{1'b1, 3'b010, 32'h12,   32'hFFFFFFFF, 32'h0,        1'b1, 2'b01};
    tbl[30] = '{1'b0, 3'b010, 32'h10,   32'h0,        32'h80227F44, 1'b0, 2'b00};

    rst0_n = 1'b0; rst3_n = 1'b0;
    set_in(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    set_in(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = obs(s);
      chk($sformatf("rst%0d_ready", s), 32'(o.rdy), 32'h1);
      chk($sformatf("rst%0d_rsp", s),   32'(o.rv),  32'h0);
      chk($sformatf("rst%0d_rdata", s), o.rd,       32'h0);
      chk($sformatf("rst%0d_fault", s), 32'(o.flt), 32'h0);
      chk($sformatf("rst%0d_cause", s), 32'(o.cs),  32'h0);
    end
    rst0_n = 1'b1; rst3_n = 1'b1;

    for (int i = 0; i < 31; i++) begin
      model(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, erd, ef, ec);
      do_req(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 1, rd, flt, cs, rdn);
      chk($sformatf("vec%0d_rdata", i), rd,       tbl[i].erd);
      chk($sformatf("vec%0d_fault", i), 32'(flt), 32'(tbl[i].ef));
      chk($sformatf("vec%0d_cause", i), 32'(cs),  32'(tbl[i].ec));
    end

    // Three wait states: latency and a request held valid across the busy window
    run_op(1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
    @(negedge clk);
    set_in(1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    g = 0;
    while (!obs(1).rdy && g < 50) begin @(negedge clk); g++; end
    @(posedge clk);
    rdyb = '0; rvb = '0; rd4 = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      o = obs(1);
      rdyb[k-1] = o.rdy; rvb[k-1] = o.rv;
      if (k == 4) rd4 = o.rd;
    end
    chk("b2b_ready", 32'(rdyb), 32'h10);
    chk("b2b_rsp",   32'(rvb),  32'h08);
    chk("b2b_rdata1", rd4, 32'hCAFEF00D);
    @(posedge clk);
    @(negedge clk);
    set_in(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    lat = 1;
    while (!obs(1).rv && lat < 40) begin @(negedge clk); lat++; end
    chk("b2b_latency2", 32'(lat), 32'h4);
    chk("b2b_rdata2", obs(1).rd, 32'hCAFEF00D);

    // Reset while a store waits: no response, store not committed
    @(negedge clk);
    @(negedge clk);
    set_in(1, 1'b1, 1'b1, 3'b010, 32'h40, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    set_in(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst3_n = 1'b0;
    #1;
    o = obs(1);
    chk("rstmid_ready", 32'(o.rdy), 32'h1);
    chk("rstmid_rsp",   32'(o.rv),  32'h0);
    @(negedge clk);
    rst3_n = 1'b1;
    saw = 1'b0;
    repeat (8) begin @(negedge clk); if (obs(1).rv) saw = 1'b1; end
    chk("rstmid_no_rsp", 32'(saw), 32'h0);
    chk("rstmid_ready_after", 32'(obs(1).rdy), 32'h1);
    run_op(1, 1'b0, 3'b010, 32'h40, 32'h0);

    random_ops(0, 200);
    random_ops(1, 40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
